// File: rtl/ttt_game_engine.sv
// ttt_game_engine: N x N tic-tac-toe engine. The computer plays against a
// stream of human moves using a fixed priority strategy (win, block, centre,
// lowest free cell) and reports win / lose / draw / timeout.
//
// Handshake: hMove has no valid/ready pair. Any value other than NONE is a
// move offer and is consumed at the first posedge it is seen in H_WAIT. The
// driver holds a move for exactly one cycle and then returns to NONE. Offers
// made in C_TURN or OVER are dropped without any response.
module ttt_game_engine #(
    parameter int N              = 3,
    parameter bit COMPUTER_FIRST = 1'b1,
    parameter int TIMEOUT        = 0,
    localparam int NN            = N * N,
    localparam int MW            = $clog2(N * N + 2)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          newGame,
    input  logic [MW-1:0] hMove,
    output logic [MW-1:0] cMove,
    output logic [1:0]    state,
    output logic          win,
    output logic          lose,
    output logic          draw,
    output logic          timeout,
    output logic          illegal
);

    typedef enum logic [1:0] {
        C_TURN = 2'b00,
        H_WAIT = 2'b01,
        OVER   = 2'b10
    } state_t;

    localparam logic [MW-1:0] NONE = '1;
    localparam state_t START       = COMPUTER_FIRST ? C_TURN : H_WAIT;
    localparam bit HAS_CENTRE      = (N % 2) == 1;
    localparam int CENTRE          = (N / 2) * N + (N / 2);
    localparam int CW              = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    // Board: one ownership bit per cell, bit i is cell i+1 (row-major).
    state_t          state_q;
    logic [NN-1:0]   comp_q;
    logic [NN-1:0]   hum_q;
    logic [CW-1:0]   idle_cnt;

    logic [NN-1:0]   occ;
    logic [MW-1:0]   win_idx, blk_idx, low_idx, pick_idx;
    logic            win_hit, blk_hit;
    logic [NN-1:0]   comp_next;
    logic            c_line, c_full;
    logic [NN-1:0]   h_oh;
    logic            h_legal, h_none;
    logic [NN-1:0]   hum_next;
    logic            h_line, h_full;

    assign state = state_q;
    assign occ   = comp_q | hum_q;

    // True when the owner mask covers any full row, column or diagonal.
    function automatic logic has_line(input logic [NN-1:0] m);
        logic any_line, row_all, col_all, d_main, d_anti;
        any_line = 1'b0;
        d_main   = 1'b1;
        d_anti   = 1'b1;
        for (int r = 0; r < N; r++) begin
            row_all = 1'b1;
            col_all = 1'b1;
            for (int c = 0; c < N; c++) begin
                row_all = row_all & m[r * N + c];
                col_all = col_all & m[c * N + r];
            end
            any_line = any_line | row_all | col_all;
            d_main   = d_main & m[r * N + r];
            d_anti   = d_anti & m[r * N + (N - 1 - r)];
        end
        return any_line | d_main | d_anti;
    endfunction

    // Computer move selection; scanning downward lets the lowest cell win.
    always_comb begin
        win_hit = 1'b0;
        blk_hit = 1'b0;
        win_idx = '0;
        blk_idx = '0;
        low_idx = '0;
        for (int i = NN - 1; i >= 0; i--) begin
            if (!occ[i]) begin
                low_idx = MW'(i);
                if (has_line(comp_q | (NN'(1) << i))) begin
                    win_hit = 1'b1;
                    win_idx = MW'(i);
                end
                if (has_line(hum_q | (NN'(1) << i))) begin
                    blk_hit = 1'b1;
                    blk_idx = MW'(i);
                end
            end
        end
        if (win_hit)                          pick_idx = win_idx;
        else if (blk_hit)                     pick_idx = blk_idx;
        else if (HAS_CENTRE && !occ[CENTRE])  pick_idx = MW'(CENTRE);
        else                                  pick_idx = low_idx;
        comp_next = comp_q | (NN'(1) << pick_idx);
        c_line    = has_line(comp_next);
        c_full    = &(comp_next | hum_q);
    end

    // Human move decode; only values 1..N*N naming a free cell are legal.
    always_comb begin
        h_oh    = '0;
        h_legal = 1'b0;
        for (int i = 0; i < NN; i++) begin
            if (hMove == MW'(i + 1)) begin
                h_oh[i] = 1'b1;
                h_legal = !occ[i];
            end
        end
        h_none   = (hMove == NONE);
        hum_next = hum_q | h_oh;
        h_line   = has_line(hum_next);
        h_full   = &(occ | h_oh);
    end

    // Game FSM with board, flags and idle counter; all outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= START;
            comp_q   <= '0;
            hum_q    <= '0;
            idle_cnt <= '0;
            cMove    <= NONE;
            win      <= 1'b0;
            lose     <= 1'b0;
            draw     <= 1'b0;
            timeout  <= 1'b0;
            illegal  <= 1'b0;
        end else if (newGame) begin
            state_q  <= START;
            comp_q   <= '0;
            hum_q    <= '0;
            idle_cnt <= '0;
            cMove    <= NONE;
            win      <= 1'b0;
            lose     <= 1'b0;
            draw     <= 1'b0;
            timeout  <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state_q)
                C_TURN: begin
                    comp_q <= comp_next;
                    cMove  <= pick_idx + MW'(1);
                    if (c_line) begin
                        win     <= 1'b1;
                        state_q <= OVER;
                    end else if (c_full) begin
                        draw    <= 1'b1;
                        state_q <= OVER;
                    end else begin
                        idle_cnt <= '0;
                        state_q  <= H_WAIT;
                    end
                end
                H_WAIT: begin
                    if (h_legal) begin
                        hum_q    <= hum_next;
                        idle_cnt <= '0;
                        if (h_line) begin
                            lose    <= 1'b1;
                            state_q <= OVER;
                        end else if (h_full) begin
                            draw    <= 1'b1;
                            state_q <= OVER;
                        end else begin
                            state_q <= C_TURN;
                        end
                    end else begin
                        // Idle cycles and rejected moves both burn the clock.
                        illegal  <= !h_none;
                        idle_cnt <= idle_cnt + CW'(1);
                        if (TIMEOUT != 0 && idle_cnt == TO_LAST) begin
                            timeout <= 1'b1;
                            state_q <= OVER;
                        end
                    end
                end
                OVER: begin
                    state_q <= OVER;
                end
                default: begin
                    state_q <= START;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ttt_game_engine.sv
// tb_ttt_game_engine: directed games against four engine configurations.
module tb_ttt_game_engine;

    logic       clock;
    logic       reset;
    logic       newGame;
    logic [4:0] hm;

    logic [3:0] a_cmove, b_cmove, d_cmove;
    logic [4:0] c_cmove;
    logic [1:0] a_state, b_state, c_state, d_state;
    logic a_win, a_lose, a_draw, a_to, a_ill;
    logic b_win, b_lose, b_draw, b_to, b_ill;
    logic c_win, c_lose, c_draw, c_to, c_ill;
    logic d_win, d_lose, d_draw, d_to, d_ill;

    int vec_cnt;
    int miss_cnt;

    localparam logic [4:0] NONE = 5'h1F;

    // 3x3, computer first, no timeout
    ttt_game_engine #(.N(3), .COMPUTER_FIRST(1'b1), .TIMEOUT(0)) dut_a (
        .clock(clock), .reset(reset), .newGame(newGame), .hMove(hm[3:0]),
        .cMove(a_cmove), .state(a_state), .win(a_win), .lose(a_lose),
        .draw(a_draw), .timeout(a_to), .illegal(a_ill));

    // 3x3, computer first, 4-cycle timeout
    ttt_game_engine #(.N(3), .COMPUTER_FIRST(1'b1), .TIMEOUT(4)) dut_b (
        .clock(clock), .reset(reset), .newGame(newGame), .hMove(hm[3:0]),
        .cMove(b_cmove), .state(b_state), .win(b_win), .lose(b_lose),
        .draw(b_draw), .timeout(b_to), .illegal(b_ill));

    // 4x4, human first
    ttt_game_engine #(.N(4), .COMPUTER_FIRST(1'b0), .TIMEOUT(0)) dut_c (
        .clock(clock), .reset(reset), .newGame(newGame), .hMove(hm),
        .cMove(c_cmove), .state(c_state), .win(c_win), .lose(c_lose),
        .draw(c_draw), .timeout(c_to), .illegal(c_ill));

    // 3x3, human first
    ttt_game_engine #(.N(3), .COMPUTER_FIRST(1'b0), .TIMEOUT(0)) dut_d (
        .clock(clock), .reset(reset), .newGame(newGame), .hMove(hm[3:0]),
        .cMove(d_cmove), .state(d_state), .win(d_win), .lose(d_lose),
        .draw(d_draw), .timeout(d_to), .illegal(d_ill));

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // driver tasks
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        newGame = 1'b0;
        hm      = NONE;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic put_move(input logic [4:0] h);
        hm = h;
        step();
        hm = NONE;
    endtask

    task automatic test_reset();
        do_reset();
        vec_cnt++;
        if (a_cmove !== 4'hF) begin
            miss_cnt++; $display("FAIL reset_cmove got %0d want 15", a_cmove);
        end
        vec_cnt++;
        if (a_state !== 2'b00) begin
            miss_cnt++; $display("FAIL reset_state got %b want 00", a_state);
        end
        vec_cnt++;
        if ({a_win, a_lose, a_draw, a_to, a_ill} !== 5'b0) begin
            miss_cnt++; $display("FAIL reset_flags got %b want 00000", {a_win, a_lose, a_draw, a_to, a_ill});
        end
        vec_cnt++;
        if (c_state !== 2'b01 || c_cmove !== 5'h1F) begin
            miss_cnt++; $display("FAIL reset_hfirst got state %b cmove %0d want 01 31", c_state, c_cmove);
        end
    endtask

    task automatic test_win();
        logic [4:0] hv [3];
        logic [3:0] cv [3];
        hv = '{5'd6, 5'd9, 5'd2};
        cv = '{4'd1, 4'd3, 4'd7};
        do_reset();
        step();
        vec_cnt++;
        if (a_cmove !== 4'd5 || a_state !== 2'b01) begin
            miss_cnt++; $display("FAIL win_open got cmove %0d state %b want 5 01", a_cmove, a_state);
        end
        for (int i = 0; i < 3; i++) begin
            put_move(hv[i]);
            vec_cnt++;
            if (a_state !== 2'b00) begin
                miss_cnt++; $display("FAIL win_hturn%0d got state %b want 00", i, a_state);
            end
            step();
            vec_cnt++;
            if (a_cmove !== cv[i]) begin
                miss_cnt++; $display("FAIL win_cmove%0d got %0d want %0d", i, a_cmove, cv[i]);
            end
        end
        vec_cnt++;
        if (a_state !== 2'b10 || a_win !== 1'b1 || a_lose !== 1'b0 || a_draw !== 1'b0) begin
            miss_cnt++; $display("FAIL win_final got state %b w%b l%b d%b want 10 w1 l0 d0", a_state, a_win, a_lose, a_draw);
        end
        // moves offered in OVER are ignored
        put_move(5'd4);
        vec_cnt++;
        if (a_ill !== 1'b0 || a_state !== 2'b10 || a_cmove !== 4'd7 || a_win !== 1'b1) begin
            miss_cnt++; $display("FAIL over_hold got ill %b state %b cmove %0d win %b want 0 10 7 1", a_ill, a_state, a_cmove, a_win);
        end
    endtask

    task automatic test_new_game();
        newGame = 1'b1;
        step();
        newGame = 1'b0;
        vec_cnt++;
        if (a_cmove !== 4'hF || a_state !== 2'b00 || {a_win, a_lose, a_draw, a_to, a_ill} !== 5'b0) begin
            miss_cnt++; $display("FAIL newgame_clear got cmove %0d state %b flags %b want 15 00 00000", a_cmove, a_state, {a_win, a_lose, a_draw, a_to, a_ill});
        end
        step();
        vec_cnt++;
        if (a_cmove !== 4'd5 || a_state !== 2'b01) begin
            miss_cnt++; $display("FAIL newgame_replay got cmove %0d state %b want 5 01", a_cmove, a_state);
        end
    endtask

    task automatic test_draw();
        logic [4:0] hv [4];
        logic [3:0] cv [4];
        hv = '{5'd1, 5'd8, 5'd7, 5'd6};
        cv = '{4'd2, 4'd3, 4'd4, 4'd9};
        do_reset();
        step();
        for (int i = 0; i < 4; i++) begin
            put_move(hv[i]);
            step();
            vec_cnt++;
            if (a_cmove !== cv[i]) begin
                miss_cnt++; $display("FAIL draw_cmove%0d got %0d want %0d", i, a_cmove, cv[i]);
            end
        end
        vec_cnt++;
        if (a_state !== 2'b10 || a_draw !== 1'b1 || a_win !== 1'b0 || a_lose !== 1'b0) begin
            miss_cnt++; $display("FAIL draw_final got state %b w%b l%b d%b want 10 w0 l0 d1", a_state, a_win, a_lose, a_draw);
        end
    endtask

    task automatic test_illegal();
        logic [4:0] bad [3];
        bad = '{5'd5, 5'd0, 5'd10};
        do_reset();
        step();
        for (int i = 0; i < 3; i++) begin
            hm = bad[i];
            step();
            vec_cnt++;
            if (a_ill !== 1'b1 || a_state !== 2'b01) begin
                miss_cnt++; $display("FAIL illegal_pulse%0d got ill %b state %b want 1 01", i, a_ill, a_state);
            end
            hm = NONE;
            step();
            vec_cnt++;
            if (a_ill !== 1'b0) begin
                miss_cnt++; $display("FAIL illegal_clear%0d got %b want 0", i, a_ill);
            end
        end
        put_move(5'd6);
        vec_cnt++;
        if (a_ill !== 1'b0 || a_state !== 2'b00) begin
            miss_cnt++; $display("FAIL illegal_accept got ill %b state %b want 0 00", a_ill, a_state);
        end
        step();
        vec_cnt++;
        if (a_cmove !== 4'd1) begin
            miss_cnt++; $display("FAIL illegal_reply got %0d want 1", a_cmove);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        step();
        for (int k = 1; k <= 4; k++) begin
            step();
            vec_cnt++;
            if (k < 4) begin
                if (b_state !== 2'b01 || b_to !== 1'b0) begin
                    miss_cnt++; $display("FAIL to_wait%0d got state %b to %b want 01 0", k, b_state, b_to);
                end
            end else begin
                if (b_state !== 2'b10 || b_to !== 1'b1 || {b_win, b_lose, b_draw} !== 3'b0) begin
                    miss_cnt++; $display("FAIL to_fire got state %b to %b wld %b want 10 1 000", b_state, b_to, {b_win, b_lose, b_draw});
                end
            end
        end
        // legal move on the 3rd edge keeps the game alive
        do_reset();
        step();
        step();
        step();
        put_move(5'd6);
        vec_cnt++;
        if (b_state !== 2'b00 || b_to !== 1'b0) begin
            miss_cnt++; $display("FAIL to_saved got state %b to %b want 00 0", b_state, b_to);
        end
        step();
        vec_cnt++;
        if (b_cmove !== 4'd1 || b_state !== 2'b01) begin
            miss_cnt++; $display("FAIL to_reply got cmove %0d state %b want 1 01", b_cmove, b_state);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            vec_cnt++;
            if (b_to !== (k == 4)) begin
                miss_cnt++; $display("FAIL to_second%0d got %b want %b", k, b_to, (k == 4));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step();
        put_move(5'd6);
        step();
        #3;
        reset = 1'b0;
        #1;
        vec_cnt++;
        if (a_cmove !== 4'hF || a_state !== 2'b00) begin
            miss_cnt++; $display("FAIL async_clear got cmove %0d state %b want 15 00", a_cmove, a_state);
        end
        step();
        reset = 1'b1;
        step();
        vec_cnt++;
        if (a_cmove !== 4'd5 || a_state !== 2'b01) begin
            miss_cnt++; $display("FAIL async_resume got cmove %0d state %b want 5 01", a_cmove, a_state);
        end
    endtask

    task automatic test_n4();
        logic [4:0] hv [7];
        logic [4:0] cv [7];
        hv = '{5'd1, 5'd5, 5'd9, 5'd6, 5'd7, 5'd11, 5'd10};
        cv = '{5'd2, 5'd3, 5'd13, 5'd4, 5'd8, 5'd16, 5'd12};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            put_move(hv[i]);
            vec_cnt++;
            if (c_state !== 2'b00 || c_lose !== 1'b0) begin
                miss_cnt++; $display("FAIL n4_hmove%0d got state %b lose %b want 00 0", i, c_state, c_lose);
            end
            step();
            vec_cnt++;
            if (c_cmove !== cv[i]) begin
                miss_cnt++; $display("FAIL n4_cmove%0d got %0d want %0d", i, c_cmove, cv[i]);
            end
        end
        vec_cnt++;
        if (c_state !== 2'b10 || c_win !== 1'b1 || c_lose !== 1'b0 || c_draw !== 1'b0) begin
            miss_cnt++; $display("FAIL n4_final got state %b w%b l%b d%b want 10 w1 l0 d0", c_state, c_win, c_lose, c_draw);
        end
    endtask

    task automatic test_lose();
        logic [4:0] hv [3];
        logic [3:0] cv [3];
        hv = '{5'd5, 5'd9, 5'd3};
        cv = '{4'd1, 4'd2, 4'd6};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            put_move(hv[i]);
            step();
            vec_cnt++;
            if (d_cmove !== cv[i]) begin
                miss_cnt++; $display("FAIL lose_cmove%0d got %0d want %0d", i, d_cmove, cv[i]);
            end
        end
        put_move(5'd7);
        vec_cnt++;
        if (d_state !== 2'b10 || d_lose !== 1'b1 || d_win !== 1'b0 || d_draw !== 1'b0 || d_cmove !== 4'd6) begin
            miss_cnt++; $display("FAIL lose_final got state %b w%b l%b d%b cmove %0d want 10 w0 l1 d0 6", d_state, d_win, d_lose, d_draw, d_cmove);
        end
    endtask

    // sequence and final report
    initial begin
        vec_cnt  = 0;
        miss_cnt = 0;
        reset    = 1'b0;
        newGame  = 1'b0;
        hm       = NONE;
        test_reset();
        test_win();
        test_new_game();
        test_draw();
        test_illegal();
        test_timeout();
        test_async_reset();
        test_n4();
        test_lose();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/ttt_game_engine.md
Name: ttt_game_engine

Overview:
- Parametrised N×N tic-tac-toe engine; the computer plays against a human move stream.
- Holds the board in registers and plays a fixed deterministic strategy.
- Detects win, loss and draw, flags illegal human moves, and enforces an optional human-move timeout.
- Successor to the fixed 3×3 scripted-response game FSM; sits between the human move input (switches/UI) and the display logic.

Parameters:
- N, 3, board side length; legal range 3..4; cells numbered 1..N*N row-major.
- COMPUTER_FIRST, 1, 1 = computer moves first after reset or newGame; 0 = human first.
- TIMEOUT, 0, number of idle H_WAIT cycles before forfeit; 0 disables the timeout.
- MW, $clog2(N*N+2), move width (localparam); the all-ones value is NONE, meaning no move.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- newGame  input  1  synchronous restart; same effect as reset, applied on the next posedge.
- hMove  input  MW  human move, cell 1..N*N, or NONE.
- cMove  output  MW  most recent computer move; NONE before the first computer move.
- state  output  2  00 C_TURN, 01 H_WAIT, 10 OVER.
- win  output  1  computer completed a line.
- lose  output  1  human completed a line.
- draw  output  1  board full, no line.
- timeout  output  1  human forfeited by timeout.
- illegal  output  1  one-cycle pulse: rejected human move.

Behaviour:
- Reset (reset=0, async) or newGame=1 at a posedge:
  - Board cleared; cMove=NONE; all flags 0; timeout counter 0.
  - state = C_TURN if COMPUTER_FIRST, else H_WAIT.
  - newGame has priority over all other inputs.
- Lines: N rows, N columns, 2 diagonals. A line is complete when all N cells carry the same owner.
- C_TURN (exactly one cycle). At the posedge the computer claims one cell, chosen by first match in this order:
  1. Lowest-numbered empty cell that completes a computer line.
  2. Lowest-numbered empty cell that completes a human line (block).
  3. Centre cell (N odd) if empty.
  4. Lowest-numbered empty cell.
- C_TURN update, same edge:
  - cMove <= chosen cell.
  - Post-move board completes a computer line: win <= 1, state <= OVER.
  - Else post-move board full: draw <= 1, state <= OVER.
  - Else state <= H_WAIT, timeout counter cleared.
- H_WAIT, each posedge:
  - hMove == NONE: counter +1. If TIMEOUT != 0 and counter reaches TIMEOUT-1 at this edge: timeout <= 1, state <= OVER.
  - hMove == 0, > N*N (not NONE), or an occupied cell: illegal=1 for the following cycle only. Board unchanged, state stays H_WAIT, counter +1 with the same timeout rule.
  - hMove is a legal empty cell: human owns it, counter cleared.
    - Completes a human line: lose <= 1, state <= OVER.
    - Else board full: draw <= 1, state <= OVER.
    - Else state <= C_TURN.
- hMove latency: a value driven after edge k is sampled at edge k+1. Hold a move one cycle, then return to NONE or the next move.
- OVER:
  - hMove ignored; no illegal pulses.
  - Flags and cMove hold.
  - Exits only via reset or newGame.
- Flag exclusivity: win, lose, draw and timeout are mutually exclusive. A final move that both completes a line and fills the board reports the line (win/lose), not draw.
- Reset mid-game: immediate async clear, regardless of state.
- Output timing: all outputs are registered; no combinational path from hMove to any output.

Test Plan:
- N=3, COMPUTER_FIRST=1, release reset, hMove 6,9,2 on successive H_WAIT cycles -> cMove 5,1,3,7; win=1, state=10 after cMove=7; lose=draw=0.
- N=3, hMove 1,8,7,6 -> cMove 5,2,3,4,9; draw=1, win=lose=0, state=10.
- After cMove=5: hMove=5 -> illegal=1 for one cycle, state stays 01. Then hMove=0 and hMove=10 -> illegal each time. Then hMove=6 -> accepted, cMove=1.
- TIMEOUT=4: after cMove=5, hold hMove=NONE -> timeout=1 and state=10 on the 4th H_WAIT edge. Repeat with a legal move on the 3rd edge -> no timeout, counter cleared.
- Mid-game: assert reset asynchronously between edges -> outputs clear immediately; play resumes with cMove=5. Separately, assert newGame in OVER -> restart identical to reset.
- N=4, COMPUTER_FIRST=0: hMove 1 -> cMove 2 (even N, no centre rule). Human fills 1,5,9 -> computer blocks 13. Verify the 4-in-line win/lose condition.
